pc_sequencer: RTL and testbench

Next-PC controller for the RV32 fetch stage. Each cycle it computes `pc_new` for the PC register from that register's current value (`pc_cur`). Inputs that drive the choice:
- instruction-memory handshake
- hazard stall
- branch/jump redirects
- trap entry
- halt

It also drives the flush strobes for the IF/ID and ID/EX pipeline registers and runs a boot/run/halt state machine.

---
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC selection for the RV32 fetch stage.
// Boot/run/halt control, pending redirects and pipeline flush strobes.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned BOOT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_cur,
   output logic [31:0] pc_new,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic        stall_id,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp_valid,
   input  logic [31:0] jmp_target,
   input  logic        trap_valid,
   input  logic [31:0] trap_vec,
   input  logic        halt,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        misalign_err,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_target_q, pend_target_d;
   logic [31:0] br_al, jmp_al;

   assign br_al  = {br_target[31:2], 2'b00};
   assign jmp_al = {jmp_target[31:2], 2'b00};
   assign state  = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= BOOT;
         cnt_q         <= 4'd0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      pc_new        = pc_cur;
      imem_req      = 1'b0;
      flush_ifid    = 1'b0;
      flush_idex    = 1'b0;
      misalign_err  = 1'b0;

      unique case (state_q)
         BOOT: begin
            pc_new     = RESET_PC;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            cnt_d      = cnt_q + 4'd1;
            if (cnt_q == BOOT_LAST) state_d = RUN;
         end
         RUN: begin
            imem_req = 1'b1;
            if (trap_valid) begin
               pc_new       = trap_vec;
               flush_ifid   = 1'b1;
               flush_idex   = 1'b1;
               pend_valid_d = 1'b0;
            end else if (pend_valid_q && imem_ack) begin
               pc_new       = pend_target_q;
               flush_ifid   = 1'b1;
               pend_valid_d = 1'b0;
            end else if (br_taken && !pend_valid_q) begin
               misalign_err = |br_target[1:0];
               flush_ifid   = 1'b1;
               flush_idex   = 1'b1;
               if (imem_ack) begin
                  pc_new = br_al;
               end else begin
                  pend_valid_d  = 1'b1;
                  pend_target_d = br_al;
               end
            end else if (jmp_valid && !pend_valid_q) begin
               misalign_err = |jmp_target[1:0];
               flush_ifid   = 1'b1;
               if (imem_ack) begin
                  pc_new = jmp_al;
               end else begin
                  pend_valid_d  = 1'b1;
                  pend_target_d = jmp_al;
               end
            end else if (halt) begin
               state_d = HALTED;
            end else if (!stall_id && imem_ack) begin
               pc_new = pc_cur + 32'd4;
            end
         end
         HALTED: begin
            if (trap_valid) begin
               state_d      = RUN;
               pc_new       = trap_vec;
               flush_ifid   = 1'b1;
               flush_idex   = 1'b1;
               pend_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = BOOT;
            cnt_d   = 4'd0;
            pc_new  = RESET_PC;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer.
// A local PC register closes the loop from pc_new back to pc_cur.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_cur, pc_new;
   logic        imem_req, imem_ack = 1'b1;
   logic        stall_id = 1'b0;
   logic        br_taken = 1'b0, jmp_valid = 1'b0;
   logic        trap_valid = 1'b0, halt = 1'b0;
   logic [31:0] br_target = '0, jmp_target = '0, trap_vec = '0;
   logic        flush_ifid, flush_idex, misalign_err;
   logic [1:0]  state;

   logic [31:0] pc_reg;
   logic        ovr = 1'b0;
   logic [31:0] ovr_val = '0;

   typedef struct {
      string       nm;
      logic [31:0] pc;
      logic        req, fi, fe, mis;
      logic [1:0]  st;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   assign pc_cur = ovr ? ovr_val : pc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_reg <= 32'd0;
      else        pc_reg <= pc_new;
   end

   pc_sequencer #(.RESET_PC(32'h0), .BOOT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .pc_new(pc_new),
      .imem_req(imem_req), .imem_ack(imem_ack), .stall_id(stall_id),
      .br_taken(br_taken), .br_target(br_target),
      .jmp_valid(jmp_valid), .jmp_target(jmp_target),
      .trap_valid(trap_valid), .trap_vec(trap_vec), .halt(halt),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .misalign_err(misalign_err), .state(state)
   );

   // Monitor: outputs are combinational, so compare mid-cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_chk++;
         if ({pc_new, imem_req, flush_ifid, flush_idex, misalign_err, state}
             !== {e.pc, e.req, e.fi, e.fe, e.mis, e.st}) begin
            n_fail++;
            $display("FAIL %s: got pc=%h req=%b fi=%b fe=%b mis=%b st=%0d, want pc=%h req=%b fi=%b fe=%b mis=%b st=%0d",
                     e.nm, pc_new, imem_req, flush_ifid, flush_idex,
                     misalign_err, state, e.pc, e.req, e.fi, e.fe,
                     e.mis, e.st);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      ovr        = 1'b0;
      stall_id   = 1'b0;
      br_taken   = 1'b0;
      jmp_valid  = 1'b0;
      trap_valid = 1'b0;
      halt       = 1'b0;
   endtask

   task automatic want(input string nm, input logic [31:0] pc,
                       input logic req, input logic fi, input logic fe,
                       input logic mis, input logic [1:0] st);
      exp_t e;
      e.nm = nm; e.pc = pc; e.req = req;
      e.fi = fi; e.fe = fe; e.mis = mis; e.st = st;
      q.push_back(e);
   endtask

   task automatic boot_seq(input string nm);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         want(nm, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
      end
      tick();
      imem_ack = 1'b1;
      want({nm, "_run0"}, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
   endtask

   initial begin
      tick();
      want("reset", 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
      tick();
      rst_n = 1'b1;
      boot_seq("boot");
      tick(); want("seq8", 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      tick(); want("seqC", 32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

      // ack stall
      tick(); ovr = 1'b1; ovr_val = 32'h100; imem_ack = 1'b0;
      want("ack_hold0", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      tick(); want("ack_hold1", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      tick(); want("ack_hold2", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      tick(); imem_ack = 1'b1;
      want("ack_resume", 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

      // branch latched while ack low, jump ignored, applied on ack
      tick(); imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h200;
      want("br_latch", 32'h104, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
      tick(); jmp_valid = 1'b1; jmp_target = 32'h300;
      want("jmp_ignored", 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      tick(); imem_ack = 1'b1;
      want("pend_apply", 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
      tick(); want("after_pend", 32'h204, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

      // trap beats pending branch, new branch and stall
      tick(); imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h400;
      want("br_latch2", 32'h204, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
      tick(); imem_ack = 1'b1; trap_valid = 1'b1; trap_vec = 32'h80;
      br_taken = 1'b1; stall_id = 1'b1;
      want("trap_prio", 32'h80, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
      tick(); want("pend_cleared", 32'h84, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

      // stall, and redirect during stall
      tick(); stall_id = 1'b1;
      want("stall_hold", 32'h84, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      tick(); want("stall_rel", 32'h88, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      tick(); stall_id = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h500;
      want("jmp_in_stall", 32'h500, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
      tick(); want("after_jmp", 32'h504, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

      // misaligned targets
      tick(); br_taken = 1'b1; br_target = 32'h203;
      want("br_misalign", 32'h200, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1);
      tick(); want("mis_once", 32'h204, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      tick(); imem_ack = 1'b0; jmp_valid = 1'b1; jmp_target = 32'h302;
      want("jmp_mis_latch", 32'h204, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
      tick(); imem_ack = 1'b1;
      want("jmp_pend_apply", 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);

      // wrap
      tick(); ovr = 1'b1; ovr_val = 32'hFFFF_FFFC;
      want("wrap", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      tick(); want("after_wrap", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

      // halt
      tick(); halt = 1'b1;
      want("halt_req", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      tick(); want("halted", 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
      tick(); br_taken = 1'b1; br_target = 32'h601;
      want("halt_br_ign", 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
      tick(); trap_valid = 1'b1; trap_vec = 32'h40;
      want("halt_trap", 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
      tick(); want("trap_run", 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

      // reset mid-operation drops a pending redirect
      tick(); imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h700;
      want("br_latch3", 32'h44, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
      tick(); rst_n = 1'b0;
      want("mid_reset", 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
      tick(); rst_n = 1'b1;
      boot_seq("reboot");

      tick();
      tick();
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d entries left, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
